// File: rtl/sram_tp_rd_stream_pkg.sv
// Shared types and helpers for the two-port SRAM read streamer.
// Optional abort/flush feature is enabled with `define SRAM_RD_STREAM_ABORT_EN.
package sram_tp_rd_stream_pkg;

  localparam int BUF_DEPTH = 3;

  typedef enum logic [1:0] {
    SRAM_RD_STREAM_IDLE  = 2'd0,
    SRAM_RD_STREAM_READ  = 2'd1,
    SRAM_RD_STREAM_DRAIN = 2'd2
  } state_e;

  // Control register: FSM state plus the read issued last cycle (data due now).
  typedef struct packed {
    state_e state;
    logic   infl;
    logic   infl_lst;
  } ctl_t;

  function automatic int func_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/sram_rd_stream_buf.sv
// 3-entry {lst, data} FIFO between the SRAM read port and the output stream.
// With SRAM_RD_STREAM_ABORT_EN a clr input empties it in one edge.
module sram_rd_stream_buf
  import sram_tp_rd_stream_pkg::*;
#(
  parameter int DATA_WD = 32
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SRAM_RD_STREAM_ABORT_EN
  input  logic             clr,
`endif
  input  logic             push,
  input  logic [DATA_WD:0] push_dat,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [DATA_WD:0] head
);

  logic [DATA_WD:0] mem [BUF_DEPTH];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end
`ifdef SRAM_RD_STREAM_ABORT_EN
    else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end
`endif
    else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sram_tp_rd_stream.sv
// Burst read initiator for a two-port SRAM with a credit-limited 3-entry output buffer.
// Define SRAM_RD_STREAM_ABORT_EN to add abort_i (flush + done pulse next cycle).
module sram_tp_rd_stream
  import sram_tp_rd_stream_pkg::*;
#(
  parameter  int SIZE    = 256,
  parameter  int DATA_WD = 32,
  localparam int SIZE_WD = func_log2(SIZE),
  localparam int LEN_WD  = SIZE_WD + 1
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SRAM_RD_STREAM_ABORT_EN
  input  logic               abort_i,
`endif
  input  logic               cmd_val_i,
  output logic               cmd_rdy_o,
  input  logic [SIZE_WD-1:0] cmd_adr_i,
  input  logic [LEN_WD-1:0]  cmd_len_i,
  output logic               sram_rd_val_o,
  output logic [SIZE_WD-1:0] sram_rd_adr_o,
  input  logic [DATA_WD-1:0] sram_rd_dat_i,
  output logic               dat_val_o,
  input  logic               dat_rdy_i,
  output logic [DATA_WD-1:0] dat_dat_o,
  output logic               dat_lst_o,
  output logic               done_o,
  output logic               busy_o
);

  // Handshake rule for both the command and data streams: a transfer happens
  // on a rising edge where valid and ready are both high; valid never drops
  // and its payload never changes until that transfer.

  ctl_t               ctl_q;
  state_e             state_nxt;
  logic [SIZE_WD-1:0] rd_adr;
  logic [LEN_WD-1:0]  rem;
  logic [1:0]         occ;
  logic [DATA_WD:0]   head;
  logic               hs_cmd;
  logic               credit_ok;
  logic               last_rd;
  logic               rd_en;
  logic               pop;
  logic               done_c;
  logic               abort_act;

  assign cmd_rdy_o = (ctl_q.state == SRAM_RD_STREAM_IDLE);
  assign busy_o    = (ctl_q.state != SRAM_RD_STREAM_IDLE);
  assign hs_cmd    = cmd_val_i & cmd_rdy_o;

  // A read is only issued when the buffer has room for it plus any data in flight.
  assign credit_ok = ({1'b0, occ} + {2'b00, ctl_q.infl}) < 3'd3;
  assign last_rd   = (rem == LEN_WD'(1));
  assign rd_en     = (ctl_q.state == SRAM_RD_STREAM_READ) & (rem != '0) & credit_ok & ~abort_act;
  assign pop       = dat_val_o & dat_rdy_i;

  assign sram_rd_val_o = rd_en;
  assign sram_rd_adr_o = rd_adr;
  assign dat_val_o     = (occ != 2'd0);
  assign dat_lst_o     = head[DATA_WD];
  assign dat_dat_o     = head[DATA_WD-1:0];

  always_comb begin
    state_nxt = ctl_q.state;
    done_c    = 1'b0;
    case (ctl_q.state)
      SRAM_RD_STREAM_IDLE: begin
        if (hs_cmd) state_nxt = (cmd_len_i == '0) ? SRAM_RD_STREAM_DRAIN : SRAM_RD_STREAM_READ;
      end
      SRAM_RD_STREAM_READ: begin
        if (rd_en && last_rd) state_nxt = SRAM_RD_STREAM_DRAIN;
      end
      SRAM_RD_STREAM_DRAIN: begin
        // Empty with nothing in flight only happens for a zero-length burst.
        if ((occ == 2'd0) && !ctl_q.infl) begin
          done_c    = 1'b1;
          state_nxt = SRAM_RD_STREAM_IDLE;
        end else if (pop && dat_lst_o) begin
          done_c    = 1'b1;
          state_nxt = SRAM_RD_STREAM_IDLE;
        end
      end
      default: state_nxt = SRAM_RD_STREAM_IDLE;
    endcase
    if (abort_act) begin
      state_nxt = SRAM_RD_STREAM_IDLE;
      done_c    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_q  <= '{SRAM_RD_STREAM_IDLE, 1'b0, 1'b0};
      rd_adr <= '0;
      rem    <= '0;
    end else begin
      ctl_q.state    <= state_nxt;
      ctl_q.infl     <= rd_en;
      ctl_q.infl_lst <= rd_en & last_rd;
      if (hs_cmd) begin
        rd_adr <= cmd_adr_i;
        rem    <= cmd_len_i;
      end else if (rd_en) begin
        rd_adr <= rd_adr + SIZE_WD'(1);
        rem    <= rem - LEN_WD'(1);
      end
    end
  end

`ifdef SRAM_RD_STREAM_ABORT_EN
  logic done_q;

  assign abort_act = abort_i & (ctl_q.state != SRAM_RD_STREAM_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= abort_act;
  end

  assign done_o = done_c | done_q;
`else
  assign abort_act = 1'b0;
  assign done_o    = done_c;
`endif

  sram_rd_stream_buf #(
    .DATA_WD (DATA_WD)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SRAM_RD_STREAM_ABORT_EN
    .clr      (abort_act),
`endif
    .push     (ctl_q.infl),
    .push_dat ({ctl_q.infl_lst, sram_rd_dat_i}),
    .pop      (pop),
    .occ      (occ),
    .head     (head)
  );

endmodule

// File: tb/tb_sram_tp_rd_stream.sv
// Self-checking bench for sram_tp_rd_stream: SRAM model, scoreboard on the output stream,
// timing checks on command/read/done. Abort scenario built when SRAM_RD_STREAM_ABORT_EN is set.
module tb_sram_tp_rd_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_val_i;
  logic        cmd_rdy_o;
  logic [7:0]  cmd_adr_i;
  logic [8:0]  cmd_len_i;
  logic        sram_rd_val_o;
  logic [7:0]  sram_rd_adr_o;
  logic [31:0] sram_rd_dat_i;
  logic        dat_val_o;
  logic        dat_rdy_i;
  logic [31:0] dat_dat_o;
  logic        dat_lst_o;
  logic        done_o;
  logic        busy_o;
  logic        abort_mon;
`ifdef SRAM_RD_STREAM_ABORT_EN
  logic        abort_i;
  assign abort_mon = abort_i;
`else
  assign abort_mon = 1'b0;
`endif

  logic [31:0] mem [256];
  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word;

  // clock / reset
  always #5 clk = ~clk;

  sram_tp_rd_stream #(
    .SIZE    (256),
    .DATA_WD (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef SRAM_RD_STREAM_ABORT_EN
    .abort_i       (abort_i),
`endif
    .cmd_val_i     (cmd_val_i),
    .cmd_rdy_o     (cmd_rdy_o),
    .cmd_adr_i     (cmd_adr_i),
    .cmd_len_i     (cmd_len_i),
    .sram_rd_val_o (sram_rd_val_o),
    .sram_rd_adr_o (sram_rd_adr_o),
    .sram_rd_dat_i (sram_rd_dat_i),
    .dat_val_o     (dat_val_o),
    .dat_rdy_i     (dat_rdy_i),
    .dat_dat_o     (dat_dat_o),
    .dat_lst_o     (dat_lst_o),
    .done_o        (done_o),
    .busy_o        (busy_o)
  );

  // SRAM model: registered read data, one cycle latency
  always @(posedge clk) begin
    if (sram_rd_val_o) sram_rd_dat_i <= mem[sram_rd_adr_o];
  end

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // scoreboard + stream-rule monitor
  always @(negedge clk) begin
    if (!rst_n || abort_mon) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_val", dat_val_o, 1'b1);
        check("stall_hold", {dat_lst_o, dat_dat_o}, prev_word);
      end
      if (dat_val_o && dat_rdy_i) begin
        if (exp_q.size() == 0) check("word_expected", 33'(exp_q.size()), 33'd1);
        else check("word", {dat_lst_o, dat_dat_o}, exp_q.pop_front());
      end
      prev_stall = dat_val_o && !dat_rdy_i;
      prev_word  = {dat_lst_o, dat_dat_o};
    end
  end

  function automatic logic rdy_pat(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return ((k % 4) == 0) || ((k % 4) == 3);
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_rdy"}, cmd_rdy_o, 1'b1);
    check({tag, "_rd_val"}, sram_rd_val_o, 1'b0);
    check({tag, "_rd_adr"}, sram_rd_adr_o, 8'h00);
    check({tag, "_dat_val"}, dat_val_o, 1'b0);
    check({tag, "_dat"}, dat_dat_o, 32'h0);
    check({tag, "_lst"}, dat_lst_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
  endtask

  // Drive one burst; exp_done >= 0 gives the required done_o cycle relative to the command.
  task automatic run_burst(input logic [7:0] adr, input logic [8:0] len, input int mode,
                           input int exp_done);
    int   k, reads, done_k, first_rd, first_val;
    logic done_seen;
    logic [7:0] a;
    @(posedge clk); #1;
    cmd_val_i = 1'b1;
    cmd_adr_i = adr;
    cmd_len_i = len;
    dat_rdy_i = rdy_pat(mode, 0);
    for (int i = 0; i < int'(len); i++) begin
      a = adr + 8'(i);
      exp_q.push_back({1'(i == int'(len) - 1), mem[a]});
    end
    k = 0; reads = 0; done_k = -1; first_rd = -1; first_val = -1; done_seen = 1'b0;
    while (!done_seen && k < 200) begin
      @(negedge clk);
      if (k == 0) check("cmd_rdy_at_T", cmd_rdy_o, 1'b1);
      if (sram_rd_val_o) begin
        a = adr + 8'(reads);
        check("rd_adr", sram_rd_adr_o, a);
        if (first_rd < 0) first_rd = k;
        reads++;
      end
      if (dat_val_o && first_val < 0) first_val = k;
      if (done_o) begin
        done_seen = 1'b1;
        done_k    = k;
      end
      @(posedge clk); #1;
      cmd_val_i = 1'b0;
      k++;
      dat_rdy_i = rdy_pat(mode, k);
    end
    check("done_seen", done_seen, 1'b1);
    check("n_reads", 33'(reads), 33'(len));
    if (exp_done >= 0) begin
      check("done_cycle", 33'(done_k), 33'(exp_done));
      if (len != 0) begin
        check("first_rd_cycle", 33'(first_rd), 33'd1);
        check("first_val_cycle", 33'(first_val), 33'd3);
      end else begin
        check("len0_no_data", 33'(first_val + 1), 33'd0);
      end
    end
    @(negedge clk);
    check("post_cmd_rdy", cmd_rdy_o, 1'b1);
    check("post_busy", busy_o, 1'b0);
    check("post_done", done_o, 1'b0);
    check("post_rd_val", sram_rd_val_o, 1'b0);
    check("queue_empty", 33'(exp_q.size()), 33'd0);
  endtask

  initial begin
    logic [7:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    rst_n = 1'b0; cmd_val_i = 1'b0; cmd_adr_i = '0; cmd_len_i = '0; dat_rdy_i = 1'b0;
`ifdef SRAM_RD_STREAM_ABORT_EN
    abort_i = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_burst(8'h10, 9'd4, 0, 6);
    run_burst(8'h10, 9'd4, 1, -1);
    run_burst(8'hFE, 9'd4, 0, 6);
    run_burst(8'h55, 9'd0, 0, 1);
    run_burst(8'hF0, 9'd20, 1, -1);

    // reset mid-burst after two words have been taken
    @(posedge clk); #1;
    cmd_val_i = 1'b1; cmd_adr_i = 8'h40; cmd_len_i = 9'd8; dat_rdy_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 8'h40 + 8'(i);
      exp_q.push_back({1'(i == 7), mem[a]});
    end
    @(posedge clk); #1;
    cmd_val_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    check("rst_words_taken", 33'(exp_q.size()), 33'd6);
    rst_n = 1'b0; dat_rdy_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    exp_q.delete();
    run_burst(8'h20, 9'd2, 0, 4);

    for (int n = 0; n < 4; n++)
      run_burst(8'($urandom_range(0, 255)), 9'($urandom_range(1, 12)), 2, -1);

`ifdef SRAM_RD_STREAM_ABORT_EN
    @(posedge clk); #1;
    cmd_val_i = 1'b1; cmd_adr_i = 8'h30; cmd_len_i = 9'd8; dat_rdy_i = 1'b0;
    @(posedge clk); #1;
    cmd_val_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    abort_i = 1'b1;
    @(negedge clk);
    check("abort_pre_val", dat_val_o, 1'b1);
    check("abort_no_rd", sram_rd_val_o, 1'b0);
    @(posedge clk); #1;
    abort_i = 1'b0;
    @(negedge clk);
    check("abort_val", dat_val_o, 1'b0);
    check("abort_done", done_o, 1'b1);
    check("abort_busy", busy_o, 1'b0);
    check("abort_cmd_rdy", cmd_rdy_o, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_done_pulse", done_o, 1'b0);
    @(posedge clk); #1;
    abort_i = 1'b1;
    @(negedge clk);
    check("idle_abort_done", done_o, 1'b0);
    @(posedge clk); #1;
    abort_i = 1'b0;
    @(negedge clk);
    check("idle_abort_done2", done_o, 1'b0);
    run_burst(8'h30, 9'd3, 0, 5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
